spi_slave_mem: RTL and testbench
================================

# spi_slave_mem

Synthesizable single-lane SPI mode-0 slave with a byte-addressable register memory. It sits directly downstream of the SPI master pins (lane 0: clock, chip-select 0, SDO0 in, SDI0 out) and serves as the bench-side responder. It lets the SPI master block be exercised end-to-end in simulation and in FPGA loopback. All SPI pins are oversampled by the system clock; there is no SCK clock domain.

## Interface
- DEPTH, 256: memory size in bytes; power of 2, 2..256; address byte taken modulo DEPTH.
- CMD_WR, 8'h02: write command opcode.
- CMD_RD, 8'h03: read command opcode.

- sys_clk_i  in  1  system clock.
- rst_i  in  1  reset: one clock, synchronous, active-high.
- spi_sck_i  in  1  SPI clock from master (spi_clk_o); CPOL=0.
- spi_csn_i  in  1  chip select from master (spi_csn0_o); active-low.
- spi_mosi_i  in  1  data from master (spi_sdo0_o).
- spi_miso_o  out  1  data to master (spi_sdi0_i).
- spi_miso_oe_o  out  1  MISO drive enable; high only in DATA_RD.
- wr_strobe_o  out  1  one-cycle pulse per byte written to memory.
- cmd_err_o  out  1  one-cycle pulse on an unrecognised opcode.
- txn_done_o  out  1  one-cycle pulse when CSN deasserts after at least one complete data byte.

## Operation
- Input sync: 2-flop synchronisers on sck, csn and mosi.
- Edge detect: registered copy of synced sck produces the rise and fall strobes.
- FSM states: IDLE, CMD, ADDR, DATA_WR, DATA_RD, IGNORE.
- IDLE -> CMD on synced CSN low.
- Synced CSN high in any state -> IDLE. The same cycle clears bit_cnt, rx_sr and tx_sr and discards any partial byte.
- bit_cnt: 3 bits, increments on every sck rise while CSN is low, wraps 7->0. A byte is complete on the rise where bit_cnt goes 7->0.
- rx_sr: on every rise, rx_sr <= {rx_sr[6:0], mosi}. The completed byte is {rx_sr[6:0], mosi}.
- CMD, byte complete:
  - CMD_WR or CMD_RD -> ADDR, remembering the direction.
  - Any other opcode -> IGNORE and pulse cmd_err_o.
- ADDR, byte complete: addr_q <= byte mod DEPTH; -> DATA_WR or DATA_RD.
- DATA_WR, byte complete: mem[addr_q] <= byte; pulse wr_strobe_o; addr_q <= addr_q+1 (wraps DEPTH-1 -> 0).
- DATA_RD, on sck fall:
  - bit_cnt == 0: tx_sr <= mem[addr_q].
  - otherwise: tx_sr <= tx_sr << 1.
- DATA_RD, byte complete: addr_q <= addr_q+1 (wraps).
- spi_miso_o = tx_sr[7] in DATA_RD, otherwise 0.
- IGNORE: no writes, MISO held 0 until CSN high.
- data_seen flag: set on any completed data byte. When CSN deasserts with data_seen set, pulse txn_done_o, then clear data_seen.
- Memory contents are not reset. addr_q, FSM state, shift registers and flags are reset.
- Reset values: spi_miso_o=0, spi_miso_oe_o=0, wr_strobe_o=0, cmd_err_o=0, txn_done_o=0, FSM=IDLE.

## Timing
- Pin edge to action latency is exactly 3 sys_clk_i cycles: 2 sync cycles plus 1 edge-detect cycle.
  - MISO changes 3 cycles after the sck fall pin edge.
  - A memory write lands 3 cycles after the 8th sck rise.
- Constraints: SCK high and low phases each ≥ 4 sys_clk_i cycles; CSN setup/hold around SCK ≥ 4 cycles.
- First read bit is valid on MISO before the first data-phase rise. It is loaded on the fall that follows the 16th rise.
- Simultaneous events:
  - CSN deassert and an sck strobe in the same cycle: CSN wins; the edge is ignored.
  - Write and address increment in the same cycle use the pre-increment addr_q.
- rst_i asserted mid-transaction: next cycle FSM=IDLE, all outputs 0.
  - If CSN is still low after reset, the block re-enters CMD. Bits of the interrupted byte are treated as a new command; the master must reassert CSN to resynchronise.
- wr_strobe_o, cmd_err_o and txn_done_o are single-cycle, registered.

## Test plan
- Write/read-back: CSN low; bytes 0x02,0x10,0xA5,0x3C; CSN high. Then 0x03,0x10 plus 2 dummy bytes.
  - Required: MISO returns 0xA5, 0x3C.
  - Required: wr_strobe_o pulses twice; txn_done_o pulses once per transaction.
- Address wrap (DEPTH=256): write 0x02,0xFF,0x11,0x22.
  - Required: reading from 0xFF gives 0x11, 0x22; reading from 0x00 gives 0x22.
- Abort mid-byte: write 0x02,0x20,0x5A, then 5 bits of 0xFF, then CSN high.
  - Required: mem[0x20]=0x5A, mem[0x21] unchanged; one wr_strobe_o pulse.
- Bad opcode: 0x7E,0x10,0xAA.
  - Required: cmd_err_o pulses once 3 cycles after the 8th rise.
  - Required: no wr_strobe_o; MISO and MISO_OE stay 0; txn_done_o not pulsed.
- Reset mid-read: during the 2nd data bit of a read, assert rst_i for 1 cycle.
  - Required: next cycle spi_miso_o=0, spi_miso_oe_o=0, FSM=IDLE.
  - Required: after CSN high, a fresh 0x03,0x10 read returns the stored value.
- Minimum-rate sweep: SCK half-period of 4 cycles, then 9 cycles.
  - Required: read-back data identical at both rates.

Source files
------------

// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave fronting a byte-addressable register memory; all pins oversampled on sys_clk_i.
// Latency: 3 clocks from pin edge to action. Backpressure: none, the master paces everything via SCK.
module spi_slave_mem #(
    parameter int         DEPTH  = 256,
    parameter logic [7:0] CMD_WR = 8'h02,
    parameter logic [7:0] CMD_RD = 8'h03
) (
    input  logic sys_clk_i,
    input  logic rst_i,
    input  logic spi_sck_i,
    input  logic spi_csn_i,
    input  logic spi_mosi_i,
    output logic spi_miso_o,
    output logic spi_miso_oe_o,
    output logic wr_strobe_o,
    output logic cmd_err_o,
    output logic txn_done_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR    = 3'd2,
        DATA_WR = 3'd3,
        DATA_RD = 3'd4,
        IGNORE  = 3'd5
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic [1:0]      sck_sync;
    logic [1:0]      csn_sync;
    logic [1:0]      mosi_sync;
    logic            sck_d;
    logic [2:0]      bit_cnt;
    logic [7:0]      rx_sr;
    logic [7:0]      tx_sr;
    logic [AW-1:0]   addr_q;
    logic            rd_q;
    logic            data_seen;
    logic [7:0]      mem [DEPTH];

    logic            sck_s;
    logic            csn_s;
    logic            mosi_s;
    logic            sck_rise;
    logic            sck_fall;
    logic            byte_done;
    logic [7:0]      byte_val;
    logic            cmd_bad;
    logic            mem_we;

    // Synchronisers are deliberately not reset so a live CSN is seen right after rst_i.
    always_ff @(posedge sys_clk_i) begin
        sck_sync  <= {sck_sync[0], spi_sck_i};
        csn_sync  <= {csn_sync[0], spi_csn_i};
        mosi_sync <= {mosi_sync[0], spi_mosi_i};
        sck_d     <= sck_sync[1];
    end

    assign sck_s     = sck_sync[1];
    assign csn_s     = csn_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sck_rise  = sck_s & ~sck_d;
    assign sck_fall  = ~sck_s & sck_d;
    assign byte_val  = {rx_sr[6:0], mosi_s};
    assign byte_done = sck_rise & ~csn_s & (bit_cnt == 3'd7);
    assign mem_we    = ~rst_i & (state_q == DATA_WR) & byte_done;

    always_comb begin
        state_nxt = state_q;
        cmd_bad   = 1'b0;
        if (csn_s) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE: state_nxt = CMD;
                CMD: begin
                    if (byte_done) begin
                        if (byte_val == CMD_WR || byte_val == CMD_RD) begin
                            state_nxt = ADDR;
                        end else begin
                            state_nxt = IGNORE;
                            cmd_bad   = 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (byte_done) begin
                        state_nxt = rd_q ? DATA_RD : DATA_WR;
                    end
                end
                DATA_WR, DATA_RD, IGNORE: state_nxt = state_q;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bit_cnt     <= 3'd0;
            rx_sr       <= 8'd0;
            tx_sr       <= 8'd0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            data_seen   <= 1'b0;
            wr_strobe_o <= 1'b0;
            cmd_err_o   <= 1'b0;
            txn_done_o  <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            wr_strobe_o <= 1'b0;
            cmd_err_o   <= cmd_bad;
            txn_done_o  <= 1'b0;
            if (csn_s) begin
                // Deselect wins over any coincident SCK edge and drops a partial byte.
                bit_cnt <= 3'd0;
                rx_sr   <= 8'd0;
                tx_sr   <= 8'd0;
                if (data_seen) begin
                    txn_done_o <= 1'b1;
                    data_seen  <= 1'b0;
                end
            end else begin
                if (sck_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sr   <= byte_val;
                end
                if (state_q == CMD && byte_done) begin
                    rd_q <= (byte_val == CMD_RD);
                end
                if (state_q == ADDR && byte_done) begin
                    addr_q <= byte_val[AW-1:0];
                end
                if ((state_q == DATA_WR || state_q == DATA_RD) && byte_done) begin
                    addr_q    <= addr_q + AW'(1);
                    data_seen <= 1'b1;
                end
                if (state_q == DATA_WR && byte_done) begin
                    wr_strobe_o <= 1'b1;
                end
                // Load on the fall that opens each byte so bit 7 is on MISO before the next rise.
                if (state_q == DATA_RD && sck_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_sr <= mem[addr_q];
                    end else begin
                        tx_sr <= {tx_sr[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Write uses the pre-increment address; contents survive reset.
    always_ff @(posedge sys_clk_i) begin
        if (mem_we) begin
            mem[addr_q] <= byte_val;
        end
    end

    assign spi_miso_o    = (state_q == DATA_RD) ? tx_sr[7] : 1'b0;
    assign spi_miso_oe_o = (state_q == DATA_RD);

endmodule

// File: tb/tb_spi_slave_mem.sv
// Directed bench for spi_slave_mem acting as a mode-0 SPI master on the pins.
// Expected data and pulse timings are hand-derived constants.
module tb_spi_slave_mem;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic csn = 1'b1;
    logic mosi = 1'b0;
    logic miso;
    logic miso_oe;
    logic wr_strobe;
    logic cmd_err;
    logic txn_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int h = 4;
    int last_rise = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    int oe_cnt = 0;
    int miso_cnt = 0;
    int wr_cyc = -1;
    int err_cyc = -1;

    spi_slave_mem dut (
        .sys_clk_i     (clk),
        .rst_i         (rst),
        .spi_sck_i     (sck),
        .spi_csn_i     (csn),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (miso_oe),
        .wr_strobe_o   (wr_strobe),
        .cmd_err_o     (cmd_err),
        .txn_done_o    (txn_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_strobe) begin
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc;
        end
        if (cmd_err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (txn_done) done_cnt <= done_cnt + 1;
        if (miso_oe) oe_cnt <= oe_cnt + 1;
        if (miso) miso_cnt <= miso_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        @(negedge clk);
        mosi = b;
        repeat (h) @(negedge clk);
        m = miso;
        sck = 1'b1;
        last_rise = cyc;
        repeat (h) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], m);
            rx[i] = m;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        csn = 1'b0;
        repeat (h) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (h) @(negedge clk);
        csn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wr_txn(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
        logic [7:0] junk;
        cs_low();
        spi_byte(8'h02, junk);
        spi_byte(a, junk);
        spi_byte(d0, junk);
        if (n > 1) spi_byte(d1, junk);
        cs_high();
    endtask

    task automatic rd_txn(input logic [7:0] a, input int n, output logic [7:0] r0, output logic [7:0] r1);
        logic [7:0] junk;
        cs_low();
        spi_byte(8'h03, junk);
        spi_byte(a, junk);
        spi_byte(8'h00, r0);
        if (n > 1) spi_byte(8'h00, r1);
        else r1 = 8'h00;
        cs_high();
    endtask

    initial begin
        logic [7:0] r0, r1, junk;
        logic m;
        int w0, e0, d0, o0, s0;

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_wr", wr_strobe, 0);
        chk("rst_err", cmd_err, 0);
        chk("rst_done", txn_done, 0);

        // Write 0xA5,0x3C at 0x10
        w0 = wr_cnt; d0 = done_cnt;
        cs_low();
        spi_byte(8'h02, junk);
        spi_byte(8'h10, junk);
        spi_byte(8'hA5, junk);
        chk("wr_latency", wr_cyc, last_rise + 3);
        spi_byte(8'h3C, junk);
        cs_high();
        chk("wr_pulses", wr_cnt - w0, 2);
        chk("wr_txn_done", done_cnt - d0, 1);

        // Read back 0x10
        d0 = done_cnt;
        cs_low();
        spi_byte(8'h03, junk);
        spi_byte(8'h10, junk);
        spi_byte(8'h00, r0);
        chk("rd_oe_high", miso_oe, 1);
        spi_byte(8'h00, r1);
        cs_high();
        chk("rd_byte0", r0, 8'hA5);
        chk("rd_byte1", r1, 8'h3C);
        chk("rd_txn_done", done_cnt - d0, 1);
        chk("rd_oe_idle", miso_oe, 0);

        // Address wrap
        wr_txn(8'hFF, 8'h11, 8'h22, 2);
        rd_txn(8'hFF, 2, r0, r1);
        chk("wrap_ff", r0, 8'h11);
        chk("wrap_00", r1, 8'h22);
        rd_txn(8'h00, 1, r0, r1);
        chk("wrap_direct_00", r0, 8'h22);

        // Abort mid-byte
        wr_txn(8'h21, 8'h77, 8'h00, 1);
        w0 = wr_cnt; d0 = done_cnt;
        cs_low();
        spi_byte(8'h02, junk);
        spi_byte(8'h20, junk);
        spi_byte(8'h5A, junk);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
        cs_high();
        chk("abort_wr_pulses", wr_cnt - w0, 1);
        chk("abort_txn_done", done_cnt - d0, 1);
        rd_txn(8'h20, 2, r0, r1);
        chk("abort_mem20", r0, 8'h5A);
        chk("abort_mem21", r1, 8'h77);

        // Bad opcode
        w0 = wr_cnt; e0 = err_cnt; d0 = done_cnt; o0 = oe_cnt; s0 = miso_cnt;
        cs_low();
        spi_byte(8'h7E, junk);
        chk("bad_err_latency", err_cyc, last_rise + 3);
        spi_byte(8'h10, junk);
        spi_byte(8'hAA, junk);
        cs_high();
        chk("bad_err_pulses", err_cnt - e0, 1);
        chk("bad_no_wr", wr_cnt - w0, 0);
        chk("bad_no_oe", oe_cnt - o0, 0);
        chk("bad_no_miso", miso_cnt - s0, 0);
        chk("bad_no_done", done_cnt - d0, 0);
        rd_txn(8'h10, 1, r0, r1);
        chk("bad_mem_intact", r0, 8'hA5);

        // Reset during the second data bit of a read
        cs_low();
        spi_byte(8'h03, junk);
        spi_byte(8'h10, junk);
        spi_bit(1'b0, m);
        chk("mid_first_bit", m, 1);
        @(negedge clk);
        mosi = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_oe_before", miso_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_miso", miso, 0);
        chk("mid_rst_oe", miso_oe, 0);
        chk("mid_rst_state", dut.state_q, 0);
        cs_high();
        rd_txn(8'h10, 1, r0, r1);
        chk("mid_fresh_read", r0, 8'hA5);

        // Slow rate, then back to fast
        h = 9;
        wr_txn(8'h40, 8'hC3, 8'h00, 1);
        rd_txn(8'h10, 2, r0, r1);
        chk("slow_rd0", r0, 8'hA5);
        chk("slow_rd1", r1, 8'h3C);
        rd_txn(8'h40, 1, r0, r1);
        chk("slow_rd40", r0, 8'hC3);
        h = 4;
        rd_txn(8'h40, 1, r0, r1);
        chk("fast_rd40", r0, 8'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
